// File: rtl/ide_pio_pkg.sv
// Shared types and 50 MHz ATA PIO timing table for the IDE PIO cycle sequencer.
// Counts are in CPU clocks: T1 address setup, T2 strobe width, TR recovery.
package ide_pio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        ACK,
        RECOVER
    } pio_state_t;

    typedef enum logic [1:0] {
        PH_T1,
        PH_T2,
        PH_TR
    } pio_phase_t;

    localparam int PIO_MAX = 4;
    localparam int CNT_W   = 5;

    // Clock count for one phase of one PIO mode; modes above PIO_MAX run as mode 4.
    function automatic logic [CNT_W-1:0] pio_count(input logic [2:0] mode,
                                                   input pio_phase_t phase);
        logic [CNT_W-1:0] t1;
        logic [CNT_W-1:0] t2;
        logic [CNT_W-1:0] tr;
        case (mode)
            3'd0:    begin t1 = 5'd4; t2 = 5'd9; tr = 5'd19; end
            3'd1:    begin t1 = 5'd3; t2 = 5'd7; tr = 5'd11; end
            3'd2:    begin t1 = 5'd2; t2 = 5'd5; tr = 5'd6;  end
            3'd3:    begin t1 = 5'd2; t2 = 5'd4; tr = 5'd4;  end
            default: begin t1 = 5'd2; t2 = 5'd4; tr = 5'd2;  end
        endcase
        case (phase)
            PH_T1:   return t1;
            PH_T2:   return t2;
            default: return tr;
        endcase
    endfunction

    function automatic logic [2:0] clamp_mode(input logic [2:0] d);
        return (d > 3'(PIO_MAX)) ? 3'(PIO_MAX) : d;
    endfunction

endpackage

// File: rtl/ide_iordy_sync.sv
// IORDY synchroniser: IORDY_SYNC-deep flop chain, reset to "ready" so a
// reset never looks like a stretch request.
module ide_iordy_sync #(
    parameter int IORDY_SYNC = 2
) (
    input  logic CLKCPU,
    input  logic RESET_n,
    input  logic IORDY,
    output logic iordy_sync
);

    logic [IORDY_SYNC-1:0] chain_reg;
    logic [IORDY_SYNC-1:0] stage_in;

    assign stage_in[0] = IORDY;

    generate
        for (genvar gi = 1; gi < IORDY_SYNC; gi++) begin : g_stage
            assign stage_in[gi] = chain_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            chain_reg <= '1;
        end else begin
            chain_reg <= stage_in;
        end
    end

    assign iordy_sync = chain_reg[IORDY_SYNC-1];

endmodule

// File: rtl/ide_pio_sequencer.sv
// ATA PIO cycle sequencer: turns each decoded IDE access into setup, strobe,
// IORDY stretch, DTACK and recovery phases timed from the programmed PIO mode.
module ide_pio_sequencer
    import ide_pio_pkg::*;
#(
    parameter int IORDY_TIMEOUT = 64,
    parameter int IORDY_SYNC    = 2
) (
    input  logic       CLKCPU,
    input  logic       RESET_n,
    input  logic       AS_CPU_n,
    input  logic       RW_n,
    input  logic       IDE_SEL,
    input  logic       IORDY,
    input  logic       CFG_WE,
    input  logic [2:0] CFG_D,
    output logic       IDE_IOR_n,
    output logic       IDE_IOW_n,
    output logic       DTACK_n,
    output logic       DATA_LE,
    output logic       BUSY,
    output logic       TIMEOUT_STS,
    output logic [2:0] MODE
);

    localparam int STR_W = $clog2(IORDY_TIMEOUT + 1);

    pio_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [STR_W-1:0] str_cnt_reg, str_cnt_next;
    logic [2:0]       cyc_mode_reg, cyc_mode_next;
    logic             cyc_read_reg, cyc_read_next;
    logic             abort_reg, abort_next;
    logic             timeout_set;

    logic [2:0]       mode_reg;
    logic             timeout_reg;
    logic             ior_n_reg;
    logic             iow_n_reg;
    logic             dtack_n_reg;
    logic             data_le_reg;
    logic             busy_reg;
    logic             iordy_s;

    ide_iordy_sync #(
        .IORDY_SYNC(IORDY_SYNC)
    ) u_iordy_sync (
        .CLKCPU    (CLKCPU),
        .RESET_n   (RESET_n),
        .IORDY     (IORDY),
        .iordy_sync(iordy_s)
    );

    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            str_cnt_reg  <= '0;
            cyc_mode_reg <= '0;
            cyc_read_reg <= 1'b1;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            str_cnt_reg  <= str_cnt_next;
            cyc_mode_reg <= cyc_mode_next;
            cyc_read_reg <= cyc_read_next;
            abort_reg    <= abort_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        str_cnt_next  = str_cnt_reg;
        cyc_mode_next = cyc_mode_reg;
        cyc_read_next = cyc_read_reg;
        abort_next    = abort_reg;
        timeout_set   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Mode and direction are frozen here for the whole cycle.
                if (IDE_SEL && !AS_CPU_n) begin
                    state_next    = SETUP;
                    cnt_next      = pio_count(mode_reg, PH_T1) - 5'd1;
                    cyc_mode_next = mode_reg;
                    cyc_read_next = RW_n;
                    abort_next    = 1'b0;
                end
            end
            SETUP: begin
                if (AS_CPU_n) begin
                    state_next = RECOVER;
                    cnt_next   = pio_count(cyc_mode_reg, PH_TR) - 5'd1;
                end else if (cnt_reg == '0) begin
                    state_next   = STROBE;
                    cnt_next     = pio_count(cyc_mode_reg, PH_T2) - 5'd1;
                    str_cnt_next = '0;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            STROBE: begin
                if (cnt_reg != '0) begin
                    // An abort still honours the full minimum strobe width.
                    cnt_next = cnt_reg - 5'd1;
                    if (AS_CPU_n) begin
                        abort_next = 1'b1;
                    end
                end else if (abort_reg || AS_CPU_n) begin
                    state_next = RECOVER;
                    cnt_next   = pio_count(cyc_mode_reg, PH_TR) - 5'd1;
                end else if (iordy_s) begin
                    state_next = ACK;
                end else if (str_cnt_reg == STR_W'(IORDY_TIMEOUT)) begin
                    state_next  = ACK;
                    timeout_set = 1'b1;
                end else begin
                    str_cnt_next = str_cnt_reg + 1'b1;
                end
            end
            ACK: begin
                if (AS_CPU_n) begin
                    state_next = RECOVER;
                    cnt_next   = pio_count(cyc_mode_reg, PH_TR) - 5'd1;
                end
            end
            RECOVER: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 5'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so each one is a clean flop.
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            ior_n_reg   <= 1'b1;
            iow_n_reg   <= 1'b1;
            dtack_n_reg <= 1'b1;
            data_le_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ior_n_reg   <= !((state_next == STROBE) && cyc_read_next);
            iow_n_reg   <= !((state_next == STROBE) && !cyc_read_next);
            dtack_n_reg <= !(state_next == ACK);
            data_le_reg <= (state_reg == STROBE) && (state_next == ACK) && cyc_read_reg;
            busy_reg    <= (state_next != IDLE);
        end
    end

    // A timeout landing in the same clock as a config write is kept, not lost.
    always_ff @(posedge CLKCPU or negedge RESET_n) begin
        if (!RESET_n) begin
            mode_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (CFG_WE) begin
                mode_reg <= clamp_mode(CFG_D);
            end
            if (timeout_set) begin
                timeout_reg <= 1'b1;
            end else if (CFG_WE) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign IDE_IOR_n   = ior_n_reg;
    assign IDE_IOW_n   = iow_n_reg;
    assign DTACK_n     = dtack_n_reg;
    assign DATA_LE     = data_le_reg;
    assign BUSY        = busy_reg;
    assign TIMEOUT_STS = timeout_reg;
    assign MODE        = mode_reg;

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for the IDE PIO sequencer: phase lengths are measured on
// falling clock edges and compared with hand-computed clock counts.
module tb_ide_pio_sequencer;

    logic       CLKCPU   = 1'b0;
    logic       RESET_n  = 1'b0;
    logic       AS_CPU_n = 1'b1;
    logic       RW_n     = 1'b1;
    logic       IDE_SEL  = 1'b0;
    logic       IORDY    = 1'b1;
    logic       CFG_WE   = 1'b0;
    logic [2:0] CFG_D    = 3'd0;
    logic       IDE_IOR_n;
    logic       IDE_IOW_n;
    logic       DTACK_n;
    logic       DATA_LE;
    logic       BUSY;
    logic       TIMEOUT_STS;
    logic [2:0] MODE;

    ide_pio_sequencer #(
        .IORDY_TIMEOUT(64),
        .IORDY_SYNC   (2)
    ) dut (
        .CLKCPU     (CLKCPU),
        .RESET_n    (RESET_n),
        .AS_CPU_n   (AS_CPU_n),
        .RW_n       (RW_n),
        .IDE_SEL    (IDE_SEL),
        .IORDY      (IORDY),
        .CFG_WE     (CFG_WE),
        .CFG_D      (CFG_D),
        .IDE_IOR_n  (IDE_IOR_n),
        .IDE_IOW_n  (IDE_IOW_n),
        .DTACK_n    (DTACK_n),
        .DATA_LE    (DATA_LE),
        .BUSY       (BUSY),
        .TIMEOUT_STS(TIMEOUT_STS),
        .MODE       (MODE)
    );

    always #5 CLKCPU = ~CLKCPU;

    int checks = 0;
    int errors = 0;

    // Running counters, written only by the monitor below.
    int ncyc = 0, ior_cnt = 0, iow_cnt = 0, le_cnt = 0, dt_cnt = 0, busy_cnt = 0;
    int last_dtack = 0, last_busy = 0, busy_rise_at = 0, strb_fall_at = 0;
    int strb_run = 0, last_run = 0;
    bit prev_busy = 1'b0;

    always @(negedge CLKCPU) begin
        ncyc++;
        if (!IDE_IOR_n) ior_cnt++;
        if (!IDE_IOW_n) iow_cnt++;
        if (DATA_LE) le_cnt++;
        if (!DTACK_n) begin
            dt_cnt++;
            last_dtack = ncyc;
        end
        if (BUSY) begin
            busy_cnt++;
            last_busy = ncyc;
            if (!prev_busy) busy_rise_at = ncyc;
        end
        prev_busy = BUSY;
        if (!IDE_IOR_n || !IDE_IOW_n) begin
            if (strb_run == 0) strb_fall_at = ncyc;
            strb_run++;
        end else if (strb_run > 0) begin
            last_run = strb_run;
            strb_run = 0;
        end
    end

    int b_ior, b_iow, b_le, b_dt, b_busy;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_ior  = ior_cnt;
        b_iow  = iow_cnt;
        b_le   = le_cnt;
        b_dt   = dt_cnt;
        b_busy = busy_cnt;
    endtask

    task automatic tick();
        @(posedge CLKCPU);
        #1;
    endtask

    task automatic start_req(input logic rd);
        tick();
        IDE_SEL  = 1'b1;
        AS_CPU_n = 1'b0;
        RW_n     = rd;
    endtask

    task automatic end_req();
        tick();
        AS_CPU_n = 1'b1;
        IDE_SEL  = 1'b0;
    endtask

    task automatic cfg(input logic [2:0] d);
        tick();
        CFG_WE = 1'b1;
        CFG_D  = d;
        tick();
        CFG_WE = 1'b0;
    endtask

    task automatic wait_dtack(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLKCPU);
            n++;
        end while (DTACK_n && n < 300);
        check_val({tag, "_dtack_seen"}, int'(DTACK_n), 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLKCPU);
            n++;
        end while (BUSY && n < 300);
        check_val({tag, "_idle"}, int'(BUSY), 0);
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLKCPU);
            n++;
        end while (IDE_IOR_n && IDE_IOW_n && n < 100);
        check_val({tag, "_strobe_seen"}, int'(IDE_IOR_n && IDE_IOW_n), 0);
    endtask

    int gap;
    int k;
    int saved_dtack;

    initial begin
        #23;
        check_val("rst_ior_n", int'(IDE_IOR_n), 1);
        check_val("rst_iow_n", int'(IDE_IOW_n), 1);
        check_val("rst_dtack_n", int'(DTACK_n), 1);
        check_val("rst_data_le", int'(DATA_LE), 0);
        check_val("rst_busy", int'(BUSY), 0);
        check_val("rst_timeout", int'(TIMEOUT_STS), 0);
        check_val("rst_mode", int'(MODE), 0);
        @(negedge CLKCPU);
        RESET_n = 1'b1;

        // Mode 0 read, IORDY ready, AS held 3 clocks past first DTACK.
        snap();
        start_req(1'b1);
        wait_dtack("m0rd");
        tick();
        tick();
        end_req();
        wait_idle("m0rd");
        tick();
        check_val("m0rd_setup", strb_fall_at - busy_rise_at, 4);
        check_val("m0rd_ior_low", last_run, 9);
        check_val("m0rd_ior_cnt", ior_cnt - b_ior, 9);
        check_val("m0rd_iow_cnt", iow_cnt - b_iow, 0);
        check_val("m0rd_data_le", le_cnt - b_le, 1);
        check_val("m0rd_dtack_len", dt_cnt - b_dt, 4);
        check_val("m0rd_recover", last_busy - last_dtack, 19);
        check_val("m0rd_busy_len", busy_cnt - b_busy, 36);
        $display("txn mode0 read: ior_low=%0d dtack=%0d busy=%0d", last_run, dt_cnt - b_dt, busy_cnt - b_busy);

        // Mode 4 write, then a second write with AS reasserted at once.
        cfg(3'd4);
        check_val("cfg_mode4", int'(MODE), 4);
        snap();
        start_req(1'b0);
        wait_dtack("m4wr1");
        end_req();
        check_val("m4wr1_iow_low", last_run, 4);
        tick();
        saved_dtack = last_dtack;
        AS_CPU_n = 1'b0;
        IDE_SEL  = 1'b1;
        wait_dtack("m4wr2");
        gap = busy_rise_at - saved_dtack - 1;
        check_val("m4wr_gap", gap, 3);
        end_req();
        wait_idle("m4wr2");
        tick();
        check_val("m4wr2_iow_low", last_run, 4);
        check_val("m4wr_iow_cnt", iow_cnt - b_iow, 8);
        check_val("m4wr_ior_cnt", ior_cnt - b_ior, 0);
        check_val("m4wr_data_le", le_cnt - b_le, 0);
        $display("txn mode4 write x2: iow_total=%0d gap=%0d", iow_cnt - b_iow, gap);

        // Mode 2 read, IORDY low for 10 clocks after the strobe falls.
        cfg(3'd2);
        snap();
        start_req(1'b1);
        wait_strobe("m2st");
        IORDY = 1'b0;
        repeat (10) @(negedge CLKCPU);
        IORDY = 1'b1;
        k = 0;
        do begin
            @(negedge CLKCPU);
            k++;
        end while (!IDE_IOR_n && k < 100);
        check_val("m2st_rise_delay", k, 3);
        end_req();
        wait_idle("m2st");
        tick();
        check_val("m2st_ior_low", last_run, 13);
        check_val("m2st_data_le", le_cnt - b_le, 1);
        check_val("m2st_timeout", int'(TIMEOUT_STS), 0);
        $display("txn mode2 read stretched: ior_low=%0d", last_run);

        // IORDY stuck low: forced completion after T2 + 64.
        tick();
        IORDY = 1'b0;
        snap();
        start_req(1'b1);
        wait_dtack("to");
        tick();
        check_val("to_ior_low", last_run, 69);
        check_val("to_sts", int'(TIMEOUT_STS), 1);
        check_val("to_dtack_n", int'(DTACK_n), 0);
        check_val("to_data_le", le_cnt - b_le, 1);
        end_req();
        IORDY = 1'b1;
        wait_idle("to");
        check_val("to_sticky", int'(TIMEOUT_STS), 1);
        cfg(3'd7);
        check_val("cfg7_mode", int'(MODE), 4);
        check_val("cfg7_sts_clr", int'(TIMEOUT_STS), 0);
        $display("txn mode2 read timeout: ior_low=%0d", last_run);

        // Abort in SETUP (mode 4).
        snap();
        start_req(1'b1);
        tick();
        AS_CPU_n = 1'b1;
        IDE_SEL  = 1'b0;
        wait_idle("absu");
        check_val("absu_ior_cnt", ior_cnt - b_ior, 0);
        check_val("absu_dtack", dt_cnt - b_dt, 0);
        check_val("absu_data_le", le_cnt - b_le, 0);
        check_val("absu_busy_len", busy_cnt - b_busy, 3);
        $display("txn mode4 abort in setup: busy=%0d", busy_cnt - b_busy);

        // Abort in the second strobe clock of mode 0.
        cfg(3'd0);
        snap();
        start_req(1'b1);
        wait_strobe("abst");
        tick();
        AS_CPU_n = 1'b1;
        IDE_SEL  = 1'b0;
        wait_idle("abst");
        tick();
        check_val("abst_ior_low", last_run, 9);
        check_val("abst_dtack", dt_cnt - b_dt, 0);
        check_val("abst_data_le", le_cnt - b_le, 0);
        check_val("abst_busy_len", busy_cnt - b_busy, 32);
        $display("txn mode0 abort in strobe: ior_low=%0d busy=%0d", last_run, busy_cnt - b_busy);

        // Asynchronous reset in the middle of a mode 3 strobe.
        cfg(3'd3);
        check_val("cfg_mode3", int'(MODE), 3);
        start_req(1'b1);
        wait_strobe("rst");
        #2;
        RESET_n = 1'b0;
        #1;
        check_val("arst_ior_n", int'(IDE_IOR_n), 1);
        check_val("arst_iow_n", int'(IDE_IOW_n), 1);
        check_val("arst_dtack_n", int'(DTACK_n), 1);
        check_val("arst_busy", int'(BUSY), 0);
        check_val("arst_mode", int'(MODE), 0);
        AS_CPU_n = 1'b1;
        IDE_SEL  = 1'b0;
        @(negedge CLKCPU);
        RESET_n = 1'b1;
        snap();
        start_req(1'b1);
        wait_dtack("post");
        end_req();
        wait_idle("post");
        tick();
        check_val("post_setup", strb_fall_at - busy_rise_at, 4);
        check_val("post_ior_low", last_run, 9);
        check_val("post_busy_len", busy_cnt - b_busy, 34);
        $display("txn post-reset mode0 read: ior_low=%0d busy=%0d", last_run, busy_cnt - b_busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ide_pio_sequencer.md
Name: ide_pio_sequencer

Overview:
- Sequences each CPU access to the IDE port as an ATA PIO cycle: address setup, strobe width, IORDY stretch, DTACK and recovery.
- Replaces fixed-delay IDE strobe/DTACK generation.
- Sits between the IDE address decode (IDE_SEL) and the IDE strobes and CPU DTACK_n.
- The PIO mode (0-4) is runtime-programmable, so every drive runs at its own rated timing.

Parameters:
- IORDY_TIMEOUT, 64: maximum clocks the strobe is stretched by IORDY low before forced completion.
- IORDY_SYNC, 2: synchroniser depth for IORDY (2 or 3).

Ports:
- CLKCPU  in  1  CPU clock (timing tables in the package are built for 50 MHz)
- RESET_n  in  1  asynchronous, active-low reset
- AS_CPU_n  in  1  CPU address strobe, active low
- RW_n  in  1  1 = read, 0 = write
- IDE_SEL  in  1  decoded IDE register access, qualified by AS, driven by the address decoder
- IORDY  in  1  drive ready, asynchronous; low requests a stretch
- CFG_WE  in  1  one-clock mode-register write strobe
- CFG_D  in  3  new PIO mode
- IDE_IOR_n  out  1  read strobe
- IDE_IOW_n  out  1  write strobe
- DTACK_n  out  1  CPU data acknowledge
- DATA_LE  out  1  one-clock read-data latch enable for the bus buffer
- BUSY  out  1  high in any state other than IDLE
- TIMEOUT_STS  out  1  sticky flag: an IORDY timeout has occurred
- MODE  out  3  current PIO mode

Behaviour:
- Reset values (asynchronous): IDE_IOR_n=1, IDE_IOW_n=1, DTACK_n=1, DATA_LE=0, BUSY=0, TIMEOUT_STS=0, MODE=0, state=IDLE. The IORDY synchroniser resets to 1.
- All outputs are registered. The cycle mode and direction are latched on leaving IDLE and held for the whole cycle.
- Counts per mode, as {T1 setup, T2 strobe, TR recovery} in clocks:
  - mode 0: {4,9,19}
  - mode 1: {3,7,11}
  - mode 2: {2,5,6}
  - mode 3: {2,4,4}
  - mode 4: {2,4,2}
- Counter is 5 bits and loads count-1 on state entry. State exits when the counter reaches 0.
- CFG_WE: MODE <= CFG_D, clamped to 4 when CFG_D > 4. The same write also clears TIMEOUT_STS. It takes effect from the next cycle start; a cycle in flight is unaffected.
- States:
  - IDLE: enter SETUP when IDE_SEL=1 and AS_CPU_n=0.
  - SETUP: both strobes high for T1 clocks, then go to STROBE.
  - STROBE: IOR_n (read) or IOW_n (write) is low.
    - After T2 clocks with synchronised IORDY=1, go to ACK.
    - If IORDY=0 at T2 expiry, stay in STROBE until IORDY=1 or IORDY_TIMEOUT extra clocks elapse.
    - On timeout, set TIMEOUT_STS and go to ACK.
  - ACK: strobe deasserted on entry. For reads, DATA_LE pulses in the same clock as the strobe rises. DTACK_n goes low on entry and is held until AS_CPU_n=1, then go to RECOVER with DTACK_n=1.
  - RECOVER: TR clocks with strobes high, then IDLE. A request pending during RECOVER is not accepted until IDLE, so the minimum cycle time is always honoured.
- Abort, when AS_CPU_n goes high before ACK:
  - In SETUP: go to RECOVER immediately, no strobe.
  - In STROBE: complete the minimum T2, then go to RECOVER. No DTACK, no DATA_LE.
- IDE_SEL going low mid-cycle is ignored; only AS_CPU_n aborts.
- CFG_WE in the same clock as a cycle start: the cycle uses the old MODE.
- IORDY is sampled only after the synchroniser, so a stretch is seen with IORDY_SYNC clocks of latency. The T2 minimum already covers this.

Decomposition:
- Package ide_pio_pkg holds:
  - state enum (IDLE, SETUP, STROBE, ACK, RECOVER);
  - PIO_MAX=4;
  - the per-mode T1/T2/TR constant table for 50 MHz;
  - the counter width.
- Sub-module ide_iordy_sync: IORDY_SYNC-deep flip-flop chain with async reset to 1.

Test Plan:
- Mode 0 read, IORDY=1: IOR_n low exactly 9 clocks, beginning 4 clocks after SETUP entry. DATA_LE pulses once. DTACK_n stays low until AS rises. Then 19 clocks of recovery before BUSY=0.
- Mode 4 write, then a back-to-back second write with AS reasserted immediately: IOW_n low 4 clocks each time. The second SETUP starts no earlier than 2 clocks after the first ACK ends.
- Mode 2 read with IORDY held low for 10 clocks after the strobe falls: IOR_n low 5 + stretch clocks. It rises IORDY_SYNC clocks after IORDY rises. TIMEOUT_STS stays 0.
- IORDY stuck low: strobe released after T2+64 clocks, TIMEOUT_STS=1, DTACK_n asserted. CFG_WE with CFG_D=7 then gives MODE=4 and TIMEOUT_STS=0.
- AS_CPU_n rises in SETUP: no strobe, no DTACK, enters RECOVER. AS rises in the 2nd STROBE clock of mode 0: strobe held the full 9 clocks, no DTACK, no DATA_LE.
- RESET_n low mid-STROBE: IOR_n, IOW_n and DTACK_n return to 1 and BUSY to 0 asynchronously, and MODE returns to 0. The first request after reset runs mode 0 timing.
